// File: rtl/gerador_trepidacao_pkg.sv
// Shared types and constants for the contact-bounce generator and its LFSR.
package gerador_trepidacao_pkg;

    typedef enum logic [1:0] {REPOUSO, TREPIDA, ASSENTA} estado_t;

    localparam logic [15:0] LFSR_MASK      = 16'hB400;
    localparam logic [15:0] SEMENTE_PADRAO = 16'hACE1;

    // Bits needed for the largest gap GAP_MIN + 2^GAP_BITS - 1, never below GAP_BITS+1.
    function automatic int gap_width(input int gap_min, input int gap_bits);
        int maxg;
        int w;
        maxg = gap_min + (1 << gap_bits) - 1;
        w    = gap_bits + 1;
        while ((1 << w) <= maxg) w++;
        return w;
    endfunction

    // The same counter times both gaps and the settle period.
    function automatic int cnt_width(input int gap_min, input int gap_bits, input int t_assenta);
        int w;
        w = gap_width(gap_min, gap_bits);
        while ((1 << w) <= t_assenta) w++;
        return w;
    endfunction

endpackage

// File: rtl/gerador_trepidacao_if.sv
// Level in / bouncing level out bundle of the contact-bounce generator.
interface gerador_trepidacao_if;
    logic       entrada;
    logic       habilita;
    logic       saida;
    logic       ocupado;
    logic [7:0] eventos;

    modport master (output entrada, output habilita, input saida, input ocupado, input eventos);
    modport slave  (input entrada, input habilita, output saida, output ocupado, output eventos);
endinterface

// File: rtl/gerador_trepidacao_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed is forced to 1.
module lfsr16
    import gerador_trepidacao_pkg::*;
#(
    parameter logic [15:0] SEMENTE = SEMENTE_PADRAO
) (
    input  logic        clkIn,
    input  logic        clr,
    output logic [15:0] estado
);
    localparam logic [15:0] INICIO = (SEMENTE == 16'h0000) ? 16'h0001 : SEMENTE;

    always_ff @(posedge clkIn or posedge clr) begin
        if (clr) estado <= INICIO;
        else     estado <= (estado >> 1) ^ (estado[0] ? LFSR_MASK : 16'h0000);
    end
endmodule

// File: rtl/gerador_trepidacao.sv
// Contact-bounce generator: on each accepted level change emits 2*N_TREP flips
// spaced by pseudo-random gaps, then holds the new level for T_ASSENTA cycles.
module gerador_trepidacao
    import gerador_trepidacao_pkg::*;
#(
    parameter int          N_TREP    = 3,
    parameter int          GAP_MIN   = 2,
    parameter int          GAP_BITS  = 2,
    parameter int          T_ASSENTA = 20,
    parameter logic [15:0] SEMENTE   = SEMENTE_PADRAO
) (
    input logic               clkIn,
    input logic               clr,
    gerador_trepidacao_if.slave bus
);
    localparam int          CW        = cnt_width(GAP_MIN, GAP_BITS, T_ASSENTA);
    localparam int          TW        = (N_TREP > 0) ? $clog2(2 * N_TREP + 1) : 1;
    localparam logic [TW-1:0] TOG_INI = TW'(2 * N_TREP);
    localparam logic [CW-1:0] SETTLE  = CW'(T_ASSENTA);
    localparam bit          BOUNCE_ON = (N_TREP > 0);

    estado_t       state;
    logic          nivel;
    logic          saida_reg;
    logic          ocupado_reg;
    logic [7:0]    eventos_reg;
    logic [TW-1:0] tog;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr;
    logic [CW-1:0] gap;
    logic          unused_lfsr_bits;

    lfsr16 #(.SEMENTE(SEMENTE)) u_lfsr (
        .clkIn  (clkIn),
        .clr    (clr),
        .estado (lfsr)
    );

    assign gap              = CW'(GAP_MIN) + CW'(lfsr[GAP_BITS-1:0]);
    assign unused_lfsr_bits = ^lfsr[15:GAP_BITS];

    always_ff @(posedge clkIn or posedge clr) begin
        if (clr) begin
            state       <= REPOUSO;
            nivel       <= 1'b0;
            saida_reg   <= 1'b0;
            ocupado_reg <= 1'b0;
            eventos_reg <= '0;
            tog         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                REPOUSO: begin
                    if (bus.entrada != nivel) begin
                        nivel       <= bus.entrada;
                        saida_reg   <= bus.entrada;
                        eventos_reg <= eventos_reg + 8'd1;
                        // habilita only matters here; the event runs to completion regardless.
                        if (bus.habilita && BOUNCE_ON) begin
                            tog         <= TOG_INI;
                            cnt         <= gap;
                            ocupado_reg <= 1'b1;
                            state       <= TREPIDA;
                        end
                    end
                end
                TREPIDA: begin
                    // A gap g loaded at edge j expires at edge j+g (count reaches 1).
                    if (cnt <= CW'(1)) begin
                        tog <= tog - TW'(1);
                        if (tog == TW'(1)) begin
                            saida_reg <= nivel;
                            cnt       <= SETTLE;
                            state     <= ASSENTA;
                        end else begin
                            saida_reg <= ~saida_reg;
                            cnt       <= gap;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ASSENTA: begin
                    if (cnt <= CW'(1)) begin
                        ocupado_reg <= 1'b0;
                        state       <= REPOUSO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= REPOUSO;
            endcase
        end
    end

    assign bus.saida   = saida_reg;
    assign bus.ocupado = ocupado_reg;
    assign bus.eventos = eventos_reg;
endmodule

// File: tb/tb_gerador_trepidacao.sv
// Bench for gerador_trepidacao: vector table for plain tracking, gap scoreboard
// driven by an independent lfsr16 instance for bounce trains.
module tb_gerador_trepidacao;
    import gerador_trepidacao_pkg::*;

    logic        clk;
    logic        clr;
    logic [15:0] ref_q;
    int          total;
    int          bad;
    int          ev_exp;
    int          gapq[$];

    gerador_trepidacao_if bus();

    gerador_trepidacao dut (
        .clkIn (clk),
        .clr   (clr),
        .bus   (bus)
    );

    lfsr16 #(.SEMENTE(16'hACE1)) ref_lfsr (
        .clkIn  (clk),
        .clr    (clr),
        .estado (ref_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic e;
        logic h;
        logic s;
        logic o;
        int   ev;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr         = 1'b1;
        bus.entrada  = 1'b0;
        bus.habilita = 1'b0;
        @(negedge clk);
        clr    = 1'b0;
        ev_exp = 0;
    endtask

    // Drive a transition to lvl and follow the whole bounce event.
    task automatic bounce(input logic lvl, input bit mid_pulse, input bit drop_settle);
        logic [15:0] pre;
        int          held;
        int          g;
        int          n;
        bit          stable;
        logic        exp;
        bus.entrada  = lvl;
        bus.habilita = 1'b1;
        pre = ref_q;
        @(posedge clk); #1;
        ev_exp = (ev_exp + 1) % 256;
        gapq.push_back(2 + int'(pre[1:0]));
        chk("accept_saida", int'(bus.saida), int'(lvl));
        chk("accept_ocupado", int'(bus.ocupado), 1);
        chk("accept_eventos", int'(bus.eventos), ev_exp);
        exp = lvl;
        for (int i = 0; i < 6; i++) begin
            if (mid_pulse && i == 1) bus.entrada = ~lvl;
            if (mid_pulse && i == 2) bus.entrada = lvl;
            held = 0;
            do begin
                pre = ref_q;
                @(posedge clk); #1;
                held++;
            end while (bus.saida == exp && held < 10);
            g = gapq.pop_front();
            chk("gap_len", held, g);
            chk("gap_range", int'(held >= 2 && held <= 5), 1);
            exp = ~exp;
            chk("flip_level", int'(bus.saida), int'(exp));
            if (i < 5) gapq.push_back(2 + int'(pre[1:0]));
        end
        n = 0;
        stable = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (drop_settle && n == 5) bus.entrada = ~lvl;
            if (bus.saida != lvl) stable = 1'b0;
        end while (bus.ocupado && n < 40);
        chk("settle_len", n, 20);
        chk("settle_level", int'(stable), 1);
        chk("event_count", int'(bus.eventos), ev_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        total = 0;
        bad   = 0;
        ev_exp = 0;

        // Reset held with the clock running, then quiet release.
        clr          = 1'b1;
        bus.entrada  = 1'b0;
        bus.habilita = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #25;
            chk("rst_saida", int'(bus.saida), 0);
            chk("rst_ocupado", int'(bus.ocupado), 0);
            chk("rst_eventos", int'(bus.eventos), 0);
        end
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_saida", int'(bus.saida), 0);
            chk("idle_eventos", int'(bus.eventos), 0);
        end

        // Bouncing disabled: saida just tracks entrada.
        vecs[0] = '{e: 1'b1, h: 1'b0, s: 1'b1, o: 1'b0, ev: 1};
        vecs[1] = '{e: 1'b1, h: 1'b0, s: 1'b1, o: 1'b0, ev: 1};
        vecs[2] = '{e: 1'b1, h: 1'b0, s: 1'b1, o: 1'b0, ev: 1};
        vecs[3] = '{e: 1'b0, h: 1'b0, s: 1'b0, o: 1'b0, ev: 2};
        vecs[4] = '{e: 1'b1, h: 1'b0, s: 1'b1, o: 1'b0, ev: 3};
        for (int i = 0; i < 5; i++) begin
            bus.entrada  = vecs[i].e;
            bus.habilita = vecs[i].h;
            @(posedge clk); #1;
            chk("vec_saida", int'(bus.saida), int'(vecs[i].s));
            chk("vec_ocupado", int'(bus.ocupado), int'(vecs[i].o));
            chk("vec_eventos", int'(bus.eventos), vecs[i].ev);
        end

        // Bounce trains: plain rise, plain fall, rise with input noise, then chained fall.
        do_reset();
        bounce(1'b1, 1'b0, 1'b0);
        bounce(1'b0, 1'b0, 1'b0);
        bounce(1'b1, 1'b1, 1'b1);
        bounce(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a train.
        bus.entrada  = 1'b1;
        bus.habilita = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        chk("midrst_saida", int'(bus.saida), 0);
        chk("midrst_ocupado", int'(bus.ocupado), 0);
        chk("midrst_eventos", int'(bus.eventos), 0);
        @(negedge clk);
        @(negedge clk);
        clr    = 1'b0;
        ev_exp = 0;
        bounce(1'b1, 1'b0, 1'b0);

        // Event counter wrap with bouncing off.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            bus.entrada = ~bus.entrada;
            @(posedge clk); #1;
            chk("wrap_saida", int'(bus.saida), int'(bus.entrada));
            if (i == 254) chk("wrap_255", int'(bus.eventos), 255);
            if (i == 255) chk("wrap_0", int'(bus.eventos), 0);
        end
        chk("wrap_ocupado", int'(bus.ocupado), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gerador_trepidacao.md
# gerador_trepidacao

Synthesizable contact-bounce generator: converts a clean level on `entrada` into a bouncing `saida` with a bounded, pseudo-random glitch train on every transition, then settles to the new level. It is the stimulus-side counterpart of the debounce (`nao_recilado`) path. It sits between a clean switch/test source and the debouncer, in silicon and in benches, so debouncers are exercised with reproducible, seed-controlled bounce.

## Interface

Parameters:
- `N_TREP`, 3: glitches per transition; each glitch is 2 flips of `saida`. 0 disables bouncing.
- `GAP_MIN`, 2: minimum cycles between flips; must be ≥1.
- `GAP_BITS`, 2: LFSR bits added to `GAP_MIN`. Gap range is `GAP_MIN .. GAP_MIN+2^GAP_BITS-1`; must be 1..8.
- `T_ASSENTA`, 20: settle cycles after the last flip before a new transition is accepted; must be ≥1.
- `SEMENTE`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.

Ports:
- `clkIn` in 1: the single clock, rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `entrada` in 1: clean input level. It is synchronous to `clkIn`.
- `habilita` in 1: 1 enables bouncing; 0 makes `saida` follow `entrada` with no glitches.
- `saida` out 1: bouncing output, registered.
- `ocupado` out 1: high from the transition cycle until the settle period ends.
- `eventos` out 8: count of accepted transitions; wraps from 255 to 0.

## Operation

- State `nivel` holds the last accepted level. The FSM has three states: REPOUSO, TREPIDA and ASSENTA.
- **REPOUSO**:
  - `saida`=`nivel` and `ocupado`=0.
  - When `entrada`≠`nivel`, on that clock edge: `nivel`←`entrada`, `saida`←`entrada`, `eventos`++.
  - If `habilita`=1 and `N_TREP`>0: load `tog`=2·`N_TREP` and the first gap, set `ocupado`=1, and go to TREPIDA.
  - Otherwise stay in REPOUSO.
- **TREPIDA**:
  - The gap counter decrements each cycle.
  - When the count expires: `saida` flips, `tog`--, and the next gap is loaded.
  - The flip that brings `tog` to 0 leaves `saida`=`nivel`, loads `T_ASSENTA`, and moves to ASSENTA.
- **ASSENTA**:
  - `saida`=`nivel`, `ocupado`=1.
  - After `T_ASSENTA` cycles, go to REPOUSO with `ocupado`=0.
- **Gap value**: `GAP_MIN + lfsr[GAP_BITS-1:0]`, sampled at the load edge. Width is `GAP_BITS+1` bits minimum, sized to hold the maximum gap.
- **LFSR**:
  - 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Shifts right every clock while `clr`=0, independent of FSM state.
- Changes on `entrada` during TREPIDA or ASSENTA are ignored. On return to REPOUSO, `entrada` is compared with `nivel` again, so the last value wins and no toggle is queued.
- `habilita` is sampled only at transition acceptance. Changing it mid-event does not alter that event.

## Timing

- **Reset** (`clr`=1, asynchronous):
  - `saida`=0, `nivel`=0, `ocupado`=0, `eventos`=0.
  - FSM in REPOUSO, `tog`=0, counters 0, `lfsr`=`SEMENTE` (or 1 if `SEMENTE`=0).
- **Latency**: `entrada` differing at edge k gives `saida`=new level and `ocupado`=1 after edge k. `eventos` increments on the same edge.
- **Gap**: a gap g loaded at edge j causes the flip at edge j+g. `saida` holds for exactly g cycles.
- **Event length**: from acceptance to `ocupado` falling is the sum of 2·`N_TREP` gaps plus `T_ASSENTA` cycles. The earliest next acceptance is the edge after `ocupado` falls.
- **Reset mid-event**: all state aborts immediately. After release, if `entrada`=1 the next edge starts a new event from `nivel`=0.
- **Wrap**: `eventos` goes from 255 to 0 on the 256th accepted event, with no flag.

## Structure

- Package `gerador_trepidacao_pkg`:
  - FSM state enum (REPOUSO, TREPIDA, ASSENTA).
  - LFSR mask constant 16'hB400.
  - Default seed constant.
  - Function for the gap counter width.
- Sub-module `lfsr16`:
  - Ports: `clkIn`, `clr`, seed parameter, 16-bit state output.
  - Free-running.
  - Reused by the bench reference model.
- The top level holds the FSM, `tog` and gap/settle counter, `nivel`, `saida` register and `eventos` counter.

## Test plan

1. **Reset**: hold `clr`=1 for 100 time units with `clkIn` running → `saida`=0, `ocupado`=0, `eventos`=0 throughout. After release with `entrada`=0, outputs stay unchanged.
2. **No bounce**: set `habilita`=0 and raise `entrada` from 0 to 1 → `saida`=1 after one edge, with no further flips. `ocupado` stays 0 and `eventos`=1.
3. **Bounce train** (defaults, seed 16'hACE1): raise `entrada` 0→1 → exactly 6 flips after the first edge. Spacing must match the `lfsr16` model and lie in 2..5 cycles. Final `saida`=1, and `ocupado` falls exactly 20 cycles after the last flip.
4. **Input changes mid-event**:
   - Pulse `entrada` 1→0→1 during TREPIDA → the event is unaffected and `eventos` is unchanged.
   - Leave `entrada`=0 at the end of ASSENTA → a new event starts on the first REPOUSO edge, with `saida`=0.
5. **Reset mid-event**: assert `clr` during TREPIDA → `saida`=0 and `ocupado`=0 immediately. After release with `entrada`=1, a new event starts and `eventos`=1.
6. **Counter wrap**: drive 256 alternating transitions with `habilita`=0 → `eventos`=0 after the 256th transition, and `saida` tracks `entrada` on each one.
